axilite_reg_poller: RTL and testbench

Synthesizable AXI-lite master that configures an instrumentation-wrapper-style slave and then samples it periodically. On start it writes one configuration word. It then repeatedly sweeps a parametrised list of register addresses, one read each, with a programmable idle period between sweeps. Every read result is emitted as a timestamped sample on a valid/ready stream. Polling stops when a selected register field matches a target value, or on abort.

---
 rtl/axilite_reg_poller_if.sv | 36 +++
 rtl/axilite_reg_poller.sv | 227 ++++++++++++++++++++++
 tb/tb_axilite_reg_poller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_reg_poller_if.sv
// rtl/axilite_reg_poller_if.sv - AXI-lite bus bundle between the poller (master) and its slave
interface axilite_reg_poller_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axilite_reg_poller.sv
// rtl/axilite_reg_poller.sv - AXI-lite master: one config write, then periodic timestamped register sweeps
module axilite_reg_poller #(
    parameter int unsigned              NUM_REGS  = 5,
    parameter logic [NUM_REGS*32-1:0]   REG_ADDRS = {32'h48, 32'h38, 32'h28, 32'h20, 32'h18},
    parameter logic [31:0]              INIT_ADDR = 32'h10,
    parameter int unsigned              PERIOD    = 10000,
    parameter int unsigned              TIMEOUT   = 8,
    parameter int unsigned              STOP_IDX  = 4,
    parameter int unsigned              STOP_MSB  = 31,
    parameter int unsigned              STOP_LSB  = 24,
    parameter int unsigned              TS_W      = 48
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [31:0]                 init_data,
    input  logic                        stop_en,
    input  logic [STOP_MSB-STOP_LSB:0]  stop_value,
    axilite_reg_poller_if.master        m_axi,
    output logic [31:0]                 smp_tdata,
    output logic [3:0]                  smp_tidx,
    output logic [TS_W-1:0]             smp_tstamp,
    output logic [1:0]                  smp_tflags,
    output logic                        smp_tvalid,
    input  logic                        smp_tready,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 late_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_RA, S_RD, S_EMIT, S_WAIT, S_DONE
    } state_t;

    state_t                     r_state;
    logic [TS_W-1:0]            r_ts;
    logic [15:0]                r_late_cnt;
    logic [3:0]                 r_idx;
    logic [15:0]                r_timer;
    logic [31:0]                r_wait_cnt;
    logic                       r_stop_en;
    logic [STOP_MSB-STOP_LSB:0] r_stop_value;
    logic                       r_stop;
    logic                       r_abort;
    logic                       r_busy;
    logic                       r_done;
    logic [31:0]                r_awaddr;
    logic                       r_awvalid;
    logic [31:0]                r_wdata;
    logic                       r_wvalid;
    logic [31:0]                r_araddr;
    logic                       r_arvalid;
    logic [31:0]                r_smp_data;
    logic [TS_W-1:0]            r_smp_ts;
    logic [1:0]                 r_smp_flags;
    logic                       r_smp_valid;

    logic                       w_aw_ok;
    logic                       w_w_ok;
    logic                       w_last_idx;
    logic                       w_stop_hit;
    logic                       w_unused;

    // Address list entry i; slice 0 is the first register of every sweep.
    function automatic logic [31:0] f_addr(input logic [3:0] i);
        return REG_ADDRS[32*i +: 32];
    endfunction

    // A channel counts as done once it was accepted earlier or is being accepted now.
    assign w_aw_ok    = !r_awvalid || m_axi.awready;
    assign w_w_ok     = !r_wvalid  || m_axi.wready;
    assign w_last_idx = (r_idx == 4'(NUM_REGS - 1));
    assign w_stop_hit = r_stop_en && (r_idx == 4'(STOP_IDX)) &&
                        (m_axi.rdata[STOP_MSB:STOP_LSB] == r_stop_value);
    // Write responses are deliberately not inspected.
    assign w_unused   = ^m_axi.bresp;

    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = 1'b1;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = 1'b1;

    assign smp_tdata  = r_smp_data;
    assign smp_tidx   = r_idx;
    assign smp_tstamp = r_smp_ts;
    assign smp_tflags = r_smp_flags;
    assign smp_tvalid = r_smp_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign late_cnt   = r_late_cnt;

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_ts <= '0;
        else           r_ts <= r_ts + TS_W'(1);
    end

    // Count read beats that arrive while no read is being waited for (saturating).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_late_cnt <= '0;
        end else if (m_axi.rvalid && (r_state != S_RD) && (r_late_cnt != 16'hFFFF)) begin
            r_late_cnt <= r_late_cnt + 16'd1;
        end
    end

    // Main sequencer: config write, read sweeps, sample emission, idle period, stop/abort.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_timer      <= '0;
            r_wait_cnt   <= '0;
            r_stop_en    <= 1'b0;
            r_stop_value <= '0;
            r_stop       <= 1'b0;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_awaddr     <= '0;
            r_awvalid    <= 1'b0;
            r_wdata      <= '0;
            r_wvalid     <= 1'b0;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_smp_data   <= '0;
            r_smp_ts     <= '0;
            r_smp_flags  <= '0;
            r_smp_valid  <= 1'b0;
        end else begin
            if (abort && r_busy) r_abort <= 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_stop_en    <= stop_en;
                        r_stop_value <= stop_value;
                        r_stop       <= 1'b0;
                        r_abort      <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_awaddr     <= INIT_ADDR;
                        r_wdata      <= init_data;
                        r_awvalid    <= 1'b1;
                        r_wvalid     <= 1'b1;
                        r_state      <= S_WR;
                    end
                end
                S_WR: begin
                    if (m_axi.awready) r_awvalid <= 1'b0;
                    if (m_axi.wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) r_state <= S_WB;
                end
                S_WB: begin
                    if (m_axi.bvalid) begin
                        r_idx     <= '0;
                        r_araddr  <= f_addr(4'd0);
                        r_arvalid <= 1'b1;
                        r_state   <= S_RA;
                    end
                end
                S_RA: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    // A beat in the expiry cycle still counts as a beat.
                    if (m_axi.rvalid) begin
                        r_smp_data  <= m_axi.rdata;
                        r_smp_ts    <= r_ts;
                        r_smp_flags <= {(m_axi.rresp != 2'b00), 1'b0};
                        r_smp_valid <= 1'b1;
                        if (w_stop_hit) r_stop <= 1'b1;
                        r_state     <= S_EMIT;
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_smp_data  <= '0;
                        r_smp_ts    <= r_ts;
                        r_smp_flags <= 2'b01;
                        r_smp_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_EMIT: begin
                    if (smp_tready) begin
                        r_smp_valid <= 1'b0;
                        if (!w_last_idx) begin
                            r_idx     <= r_idx + 4'd1;
                            r_araddr  <= f_addr(r_idx + 4'd1);
                            r_arvalid <= 1'b1;
                            r_state   <= S_RA;
                        end else if (r_stop || r_abort || abort) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wait_cnt <= '0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 32'(PERIOD - 1)) begin
                        r_idx     <= '0;
                        r_araddr  <= f_addr(4'd0);
                        r_arvalid <= 1'b1;
                        r_state   <= S_RA;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_reg_poller.sv
// tb/tb_axilite_reg_poller.sv - directed self-checking bench for axilite_reg_poller
module tb_axilite_reg_poller;
    localparam int T_PERIOD  = 20;
    localparam int T_TIMEOUT = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic [47:0] ts;
        logic [1:0]  flags;
    } smp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] init_data;
    logic        stop_en;
    logic [7:0]  stop_value;
    logic [31:0] smp_tdata;
    logic [3:0]  smp_tidx;
    logic [47:0] smp_tstamp;
    logic [1:0]  smp_tflags;
    logic        smp_tvalid;
    logic        smp_tready;
    logic        busy;
    logic        done;
    logic [15:0] late_cnt;

    axilite_reg_poller_if axi ();

    axilite_reg_poller #(.PERIOD(T_PERIOD), .TIMEOUT(T_TIMEOUT)) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .start      (start),
        .abort      (abort),
        .init_data  (init_data),
        .stop_en    (stop_en),
        .stop_value (stop_value),
        .m_axi      (axi.master),
        .smp_tdata  (smp_tdata),
        .smp_tidx   (smp_tidx),
        .smp_tstamp (smp_tstamp),
        .smp_tflags (smp_tflags),
        .smp_tvalid (smp_tvalid),
        .smp_tready (smp_tready),
        .busy       (busy),
        .done       (done),
        .late_cnt   (late_cnt)
    );

    int checks = 0;
    int fails  = 0;

    // slave configuration, written only by the test sequence
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          withhold_en = 0;
    logic [31:0] withhold_addr = 32'h28;
    int          stop_sweep = 0;
    bit          tready_en = 1;
    int          clr_gen = 0;

    // slave/monitor state, written only by the slave process
    int          clr_seen = 0;
    int          aw_hi, w_hi, aw_cyc, w_cyc, aw_acc, w_acc, b_sent, late_timer, h48_cnt;
    logic [31:0] aw_addr_log, w_data_log;
    logic [3:0]  w_strb_log;
    logic [31:0] rpend_q[$];
    logic [31:0] ar_addr_q[$];
    logic [47:0] ar_ts_q[$];
    smp_t        smp_q[$];
    logic [47:0] tb_ts = 0;

    logic [31:0] exp_addr [5] = '{32'h18, 32'h20, 32'h28, 32'h38, 32'h48};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference timestamp: number of clock edges since reset release
    always @(posedge clk) tb_ts <= rst_n ? tb_ts + 48'd1 : 48'd0;

    // AXI-lite slave and stream sink, driven mid-cycle
    always @(negedge clk) begin
        logic [31:0] a;
        if (clr_seen != clr_gen) begin
            aw_hi = 0; w_hi = 0; aw_cyc = 0; w_cyc = 0; aw_acc = 0; w_acc = 0;
            b_sent = 0; late_timer = 0; h48_cnt = 0;
            aw_addr_log = 0; w_data_log = 0; w_strb_log = 0;
            rpend_q.delete(); ar_addr_q.delete(); ar_ts_q.delete(); smp_q.delete();
            clr_seen = clr_gen;
        end
        if (axi.awvalid) begin axi.awready = (aw_hi >= aw_delay); aw_hi++; aw_cyc++; end
        else begin axi.awready = 1'b0; aw_hi = 0; end
        if (axi.wvalid) begin axi.wready = (w_hi >= w_delay); w_hi++; w_cyc++; end
        else begin axi.wready = 1'b0; w_hi = 0; end
        axi.bvalid  = (((aw_acc < w_acc) ? aw_acc : w_acc) > b_sent);
        axi.bresp   = 2'b10;
        axi.arready = 1'b1;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        if (late_timer > 0) begin
            late_timer--;
            if (late_timer == 0) begin axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; end
        end
        if (rpend_q.size() > 0) begin
            a = rpend_q.pop_front();
            if (withhold_en && a == withhold_addr) late_timer = T_TIMEOUT + 1;
            else begin
                axi.rvalid = 1'b1;
                axi.rdata  = a;
                if (a == 32'h48) begin
                    h48_cnt++;
                    if (h48_cnt == stop_sweep) axi.rdata = 32'h02AB_CDEF;
                end
            end
        end
        smp_tready = tready_en;
        if (axi.awvalid && axi.awready) begin aw_acc++; aw_addr_log = axi.awaddr; end
        if (axi.wvalid && axi.wready) begin w_acc++; w_data_log = axi.wdata; w_strb_log = axi.wstrb; end
        if (axi.bvalid && axi.bready) b_sent++;
        if (axi.arvalid && axi.arready) begin
            rpend_q.push_back(axi.araddr);
            ar_addr_q.push_back(axi.araddr);
            ar_ts_q.push_back(tb_ts);
        end
        if (smp_tvalid && smp_tready)
            smp_q.push_back('{data: smp_tdata, idx: smp_tidx, ts: smp_tstamp, flags: smp_tflags});
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        clr_gen++;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); #1; start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; @(negedge clk); #1; abort = 1'b0;
    endtask

    task automatic wait_samples(input int n, input int max_cyc, input string tag);
        int k;
        for (k = 0; k < max_cyc && smp_q.size() < n; k++) begin @(negedge clk); #1; end
        if (smp_q.size() < n) begin
            checks++; fails++;
            $display("FAIL %s_wait_samples: got %0d samples want %0d", tag, smp_q.size(), n);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int k;
        for (k = 0; k < max_cyc && done !== 1'b1; k++) begin @(negedge clk); #1; end
        if (done !== 1'b1) begin
            checks++; fails++;
            $display("FAIL %s_wait_done: done still %0d", tag, done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        clr_gen++;
        repeat (2) @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0d want 0", done); end
        checks++; if ({axi.awvalid, axi.wvalid, axi.arvalid, smp_tvalid} !== 4'b0000) begin fails++; $display("FAIL reset_valids: got %b want 0000", {axi.awvalid, axi.wvalid, axi.arvalid, smp_tvalid}); end
        checks++; if ({axi.bready, axi.rready} !== 2'b11) begin fails++; $display("FAIL reset_readies: got %b want 11", {axi.bready, axi.rready}); end
        checks++; if (late_cnt !== 16'd0) begin fails++; $display("FAIL reset_late_cnt: got %0d want 0", late_cnt); end
        checks++; if (smp_tstamp !== 48'd0) begin fails++; $display("FAIL reset_tstamp: got %0d want 0", smp_tstamp); end
        checks++; if ({axi.awaddr, axi.wdata, axi.araddr, smp_tdata} !== 128'd0) begin fails++; $display("FAIL reset_addr_data: got %h want 0", {axi.awaddr, axi.wdata, axi.araddr, smp_tdata}); end
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk); #1;
        checks++; if ({busy, done, axi.awvalid} !== 3'b000) begin fails++; $display("FAIL reset_idle_hold: got %b want 000", {busy, done, axi.awvalid}); end
    endtask

    task automatic test_basic_sweep();
        aw_delay = 0; w_delay = 0; withhold_en = 0; stop_sweep = 0; tready_en = 1;
        do_reset();
        init_data = (32'd1 << 16) | 32'd3; stop_en = 1'b0; stop_value = 8'h00;
        pulse_start();
        wait_samples(10, 1000, "basic");
        init_data = 32'hFFFF_FFFF;
        pulse_start();
        pulse_abort();
        wait_done(500, "basic");
        checks++; if (aw_acc !== 1) begin fails++; $display("FAIL basic_write_count: got %0d want 1", aw_acc); end
        checks++; if (aw_addr_log !== 32'h10) begin fails++; $display("FAIL basic_awaddr: got %h want 10", aw_addr_log); end
        checks++; if (w_data_log !== 32'h0001_0003) begin fails++; $display("FAIL basic_wdata: got %h want 00010003", w_data_log); end
        checks++; if (w_strb_log !== 4'hF) begin fails++; $display("FAIL basic_wstrb: got %h want f", w_strb_log); end
        checks++; if (smp_q.size() !== 15) begin fails++; $display("FAIL basic_sample_count: got %0d want 15", smp_q.size()); end
        for (int i = 0; i < smp_q.size() && i < ar_ts_q.size(); i++) begin
            checks++;
            if (smp_q[i].idx !== 4'(i % 5) || smp_q[i].data !== exp_addr[i % 5] ||
                smp_q[i].flags !== 2'b00 || smp_q[i].ts !== ar_ts_q[i] + 48'd1) begin
                fails++;
                $display("FAIL basic_sample%0d: got idx=%0d data=%h flags=%b ts=%0d want idx=%0d data=%h flags=00 ts=%0d",
                         i, smp_q[i].idx, smp_q[i].data, smp_q[i].flags, smp_q[i].ts, i % 5, exp_addr[i % 5], ar_ts_q[i] + 48'd1);
            end
        end
        if (smp_q.size() >= 6) begin
            checks++; if (smp_q[1].ts - smp_q[0].ts !== 48'd3) begin fails++; $display("FAIL basic_read_spacing: got %0d want 3", smp_q[1].ts - smp_q[0].ts); end
            checks++; if (smp_q[5].ts - smp_q[0].ts !== 48'(T_PERIOD + 15)) begin fails++; $display("FAIL basic_sweep_spacing: got %0d want %0d", smp_q[5].ts - smp_q[0].ts, T_PERIOD + 15); end
        end
        checks++; if ({done, busy} !== 2'b10) begin fails++; $display("FAIL basic_abort_done: got done,busy=%b want 10", {done, busy}); end
    endtask

    task automatic test_write_delay();
        aw_delay = 2; w_delay = 0; withhold_en = 0; stop_sweep = 0; tready_en = 1;
        do_reset();
        init_data = 32'h0000_00A5; stop_en = 1'b0;
        pulse_start();
        pulse_abort();
        wait_done(300, "wdelay");
        checks++; if (aw_cyc !== 3) begin fails++; $display("FAIL wdelay_awvalid_cycles: got %0d want 3", aw_cyc); end
        checks++; if (w_cyc !== 1) begin fails++; $display("FAIL wdelay_wvalid_cycles: got %0d want 1", w_cyc); end
        checks++; if (aw_acc !== 1 || w_acc !== 1 || b_sent !== 1) begin fails++; $display("FAIL wdelay_single_write: got aw=%0d w=%0d b=%0d want 1 1 1", aw_acc, w_acc, b_sent); end
        checks++; if (smp_q.size() !== 5) begin fails++; $display("FAIL wdelay_samples: got %0d want 5", smp_q.size()); end
        aw_delay = 0;
    endtask

    task automatic test_timeout();
        aw_delay = 0; w_delay = 0; withhold_en = 1; withhold_addr = 32'h28; stop_sweep = 0; tready_en = 1;
        do_reset();
        init_data = 32'h0; stop_en = 1'b0;
        pulse_start();
        pulse_abort();
        wait_done(300, "timeout");
        checks++; if (smp_q.size() !== 5) begin fails++; $display("FAIL timeout_samples: got %0d want 5", smp_q.size()); end
        if (smp_q.size() >= 4 && ar_ts_q.size() >= 3) begin
            checks++; if (smp_q[2].flags !== 2'b01 || smp_q[2].data !== 32'h0 || smp_q[2].idx !== 4'd2) begin fails++; $display("FAIL timeout_sample2: got flags=%b data=%h idx=%0d want 01 0 2", smp_q[2].flags, smp_q[2].data, smp_q[2].idx); end
            checks++; if (smp_q[2].ts !== ar_ts_q[2] + 48'(T_TIMEOUT)) begin fails++; $display("FAIL timeout_tstamp: got %0d want %0d", smp_q[2].ts, ar_ts_q[2] + 48'(T_TIMEOUT)); end
            checks++; if (smp_q[3].data !== 32'h38 || smp_q[3].flags !== 2'b00) begin fails++; $display("FAIL timeout_next_read: got data=%h flags=%b want 38 00", smp_q[3].data, smp_q[3].flags); end
        end
        checks++; if (late_cnt !== 16'd1) begin fails++; $display("FAIL timeout_late_cnt: got %0d want 1", late_cnt); end
        withhold_en = 0;
    endtask

    task automatic test_stop_match();
        int n_ar;
        aw_delay = 0; w_delay = 0; withhold_en = 0; stop_sweep = 3; tready_en = 1;
        do_reset();
        init_data = 32'h0; stop_en = 1'b1; stop_value = 8'h02;
        pulse_start();
        wait_done(1000, "stop");
        checks++; if (smp_q.size() !== 15) begin fails++; $display("FAIL stop_samples: got %0d want 15", smp_q.size()); end
        checks++; if ({done, busy} !== 2'b10) begin fails++; $display("FAIL stop_done_busy: got %b want 10", {done, busy}); end
        if (smp_q.size() >= 15) begin
            checks++; if (smp_q[14].data !== 32'h02AB_CDEF) begin fails++; $display("FAIL stop_match_data: got %h want 02abcdef", smp_q[14].data); end
        end
        repeat (60) @(negedge clk); #1;
        n_ar = ar_addr_q.size();
        checks++; if (n_ar !== 15) begin fails++; $display("FAIL stop_no_4th_sweep: got %0d ARs want 15", n_ar); end
    endtask

    task automatic test_back_to_back();
        stop_en = 1'b0; init_data = 32'h0000_5A5A;
        pulse_start();
        repeat (3) @(negedge clk); #1;
        checks++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL restart_busy_done: got %b want 10", {busy, done}); end
        checks++; if (aw_acc !== 2 || w_data_log !== 32'h0000_5A5A) begin fails++; $display("FAIL restart_write: got count=%0d data=%h want 2 00005a5a", aw_acc, w_data_log); end
        pulse_abort();
        wait_done(300, "restart");
        checks++; if (smp_q.size() !== 20) begin fails++; $display("FAIL restart_samples: got %0d want 20", smp_q.size()); end
    endtask

    task automatic test_stall_abort();
        int   k;
        int   bad;
        smp_t held;
        aw_delay = 0; w_delay = 0; withhold_en = 0; stop_sweep = 0; tready_en = 0;
        do_reset();
        init_data = 32'h1; stop_en = 1'b0;
        pulse_start();
        for (k = 0; k < 100 && smp_tvalid !== 1'b1; k++) begin @(negedge clk); #1; end
        checks++; if (smp_tvalid !== 1'b1) begin fails++; $display("FAIL stall_first_valid: got %0d want 1", smp_tvalid); end
        held = '{data: smp_tdata, idx: smp_tidx, ts: smp_tstamp, flags: smp_tflags};
        init_data = 32'hFFFF_0000;
        pulse_start();
        bad = 0;
        for (k = 0; k < 50; k++) begin
            if (smp_tvalid !== 1'b1 || smp_tdata !== held.data || smp_tidx !== held.idx ||
                smp_tstamp !== held.ts || smp_tflags !== held.flags || axi.arvalid !== 1'b0) bad++;
            @(negedge clk); #1;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
        checks++; if (ar_addr_q.size() !== 1) begin fails++; $display("FAIL stall_no_new_ar: got %0d ARs want 1", ar_addr_q.size()); end
        checks++; if (held.data !== 32'h18 || held.idx !== 4'd0) begin fails++; $display("FAIL stall_held_fields: got data=%h idx=%0d want 18 0", held.data, held.idx); end
        tready_en = 1;
        wait_samples(2, 100, "stall");
        pulse_abort();
        wait_done(300, "stall");
        checks++; if (smp_q.size() !== 5 || ar_addr_q.size() !== 5) begin fails++; $display("FAIL abort_sweep_finish: got samples=%0d ars=%0d want 5 5", smp_q.size(), ar_addr_q.size()); end
        checks++; if (aw_acc !== 1 || w_data_log !== 32'h1) begin fails++; $display("FAIL busy_start_ignored: got writes=%0d data=%h want 1 00000001", aw_acc, w_data_log); end
        repeat (40) @(negedge clk); #1;
        checks++; if ({done, busy} !== 2'b10 || ar_addr_q.size() !== 5) begin fails++; $display("FAIL abort_stays_done: got done,busy=%b ars=%0d want 10 5", {done, busy}, ar_addr_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        init_data = 32'h0; stop_en = 1'b0; stop_value = 8'h0;
        test_reset();
        test_basic_sweep();
        test_write_delay();
        test_timeout();
        test_stop_match();
        test_back_to_back();
        test_stall_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
